// File: rtl/axis_multi_channel_packet_checker_if.sv
// AXI-Stream bundle carried into the packet checker (no TID/TUSER: the checker ignores them).
interface axis_multi_channel_packet_checker_if #(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned DEST_W     = 4
) ();
  logic [8*DATA_BYTES-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;
  logic [DEST_W-1:0]       tdest;

  modport master (output tdata, tkeep, tlast, tvalid, tdest, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, tdest, output tready);
endinterface

// File: rtl/axis_multi_channel_packet_checker.sv
// Per-TDEST AXIS packet checker: classifies packets good/bad per channel, tracks sequence
// gaps, keeps saturating statistics and drives programmable backpressure.
module axis_multi_channel_packet_checker #(
  parameter int unsigned DATA_BYTES    = 8,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned MAX_PKT_BYTES = 9600,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter logic [15:0] LFSR_SEED     = 16'h1,
  parameter int unsigned DEST_W        = 4,
  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                  clk,
  input  logic                                  areset,
  axis_multi_channel_packet_checker_if.slave    axis_in,
  input  logic [1:0]                            bp_mode_i,
  input  logic                                  clear_stats_i,
  input  logic [CH_W-1:0]                       stat_sel_i,
  output logic [CNT_WIDTH-1:0]                  stat_good_o,
  output logic [CNT_WIDTH-1:0]                  stat_bad_o,
  output logic [CNT_WIDTH-1:0]                  stat_lost_o,
  output logic [NUM_CHANNELS-1:0]               err_sticky_o,
  output logic                                  pkt_done_o,
  output logic                                  pkt_ok_o,
  output logic [CH_W-1:0]                       pkt_chan_o
);
  // Byte counter must hold MAX_PKT_BYTES+1 plus one more beat before clamping.
  localparam int unsigned BC_W = $clog2(MAX_PKT_BYTES + DATA_BYTES + 2);
  localparam int unsigned KC_W = $clog2(DATA_BYTES + 1);
  localparam int unsigned LW   = CNT_WIDTH + 1;

  if (DATA_BYTES < 4) begin : g_width_check
    $error("DATA_BYTES must be >= 4 so the header fits in the first beat");
  end

  typedef enum logic {StIdle, StBody} state_e;

  state_e                state_q    [NUM_CHANNELS], state_d    [NUM_CHANNELS];
  logic [BC_W-1:0]       byte_cnt_q [NUM_CHANNELS], byte_cnt_d [NUM_CHANNELS];
  logic [15:0]           hdr_seq_q  [NUM_CHANNELS], hdr_seq_d  [NUM_CHANNELS];
  logic [15:0]           hdr_len_q  [NUM_CHANNELS], hdr_len_d  [NUM_CHANNELS];
  logic [15:0]           exp_seq_q  [NUM_CHANNELS], exp_seq_d  [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]  good_q     [NUM_CHANNELS], good_d     [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]  bad_q      [NUM_CHANNELS], bad_d      [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]  lost_q     [NUM_CHANNELS], lost_d     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] err_q, err_d, sync_q, sync_d, sticky_q, sticky_d;
  logic                  done_q, done_d, ok_q, ok_d;
  logic [CH_W-1:0]       chan_q, chan_d;
  logic [CNT_WIDTH-1:0]  stat_good_q, stat_bad_q, stat_lost_q;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [1:0]            bp_cnt_q, bp_cnt_d;
  logic                  tready_q, tready_d;

  logic                  beat, dest_ok, first, keep_contig, beat_err, mismatch, overflow;
  logic                  err_new, short_pkt, good;
  logic [CH_W-1:0]       ch;
  logic [KC_W-1:0]       popcnt;
  logic [BC_W-1:0]       base, sum, cnt_new, idx;
  logic [15:0]           seq_cur, len_cur, gap;
  logic [LW-1:0]         lost_sum;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Beat classification, per-channel FSM next state, sequence tracking and statistics.
  always_comb begin
    state_d   = state_q;   byte_cnt_d = byte_cnt_q; hdr_seq_d = hdr_seq_q;
    hdr_len_d = hdr_len_q; exp_seq_d  = exp_seq_q;  good_d    = good_q;
    bad_d     = bad_q;     lost_d     = lost_q;     err_d     = err_q;
    sync_d    = sync_q;    sticky_d   = sticky_q;
    done_d    = 1'b0;      ok_d       = 1'b0;       chan_d    = '0;

    beat    = axis_in.tvalid & tready_q;
    dest_ok = 32'(axis_in.tdest) < NUM_CHANNELS;
    ch      = dest_ok ? axis_in.tdest[CH_W-1:0] : '0;
    first   = (state_q[ch] == StIdle);

    popcnt = '0;
    for (int j = 0; j < DATA_BYTES; j++) popcnt += KC_W'(axis_in.tkeep[j]);
    // Contiguous-from-lane-0 masks are of the form 0..01..1.
    keep_contig = (axis_in.tkeep != '0) &&
                  ((axis_in.tkeep & (axis_in.tkeep + DATA_BYTES'(1))) == '0);
    beat_err    = axis_in.tlast ? !keep_contig : !(&axis_in.tkeep);

    base     = first ? '0 : byte_cnt_q[ch];
    sum      = base + BC_W'(popcnt);
    overflow = sum > BC_W'(MAX_PKT_BYTES);
    cnt_new  = overflow ? BC_W'(MAX_PKT_BYTES + 1) : sum;
    seq_cur  = first ? axis_in.tdata[15:0]  : hdr_seq_q[ch];
    len_cur  = first ? axis_in.tdata[31:16] : hdr_len_q[ch];

    mismatch = 1'b0;
    idx      = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      idx = base + BC_W'(j);
      if (axis_in.tkeep[j] && (idx >= BC_W'(4)) &&
          (axis_in.tdata[8*j +: 8] != seq_cur[7:0] + 8'(idx))) begin
        mismatch = 1'b1;
      end
    end

    err_new   = (!first && err_q[ch]) || beat_err || mismatch || overflow;
    short_pkt = cnt_new < BC_W'(4);
    good      = !err_new && !short_pkt && (32'(cnt_new) == 32'(len_cur));
    gap       = seq_cur - exp_seq_q[ch];
    lost_sum  = {1'b0, lost_q[ch]} + LW'(gap);

    if (beat && !dest_ok && axis_in.tlast) begin
      // Unknown destination: the packet is charged to channel 0 as bad.
      done_d      = 1'b1;
      bad_d[0]    = sat_inc(bad_q[0]);
      sticky_d[0] = 1'b1;
    end else if (beat && dest_ok) begin
      if (!axis_in.tlast) begin
        state_d[ch]    = StBody;
        byte_cnt_d[ch] = cnt_new;
        hdr_seq_d[ch]  = seq_cur;
        hdr_len_d[ch]  = len_cur;
        err_d[ch]      = err_new;
      end else begin
        state_d[ch] = StIdle;
        err_d[ch]   = 1'b0;
        done_d      = 1'b1;
        ok_d        = good;
        chan_d      = ch;
        if (good) begin
          good_d[ch] = sat_inc(good_q[ch]);
        end else begin
          bad_d[ch]    = sat_inc(bad_q[ch]);
          sticky_d[ch] = 1'b1;
        end
        if (!short_pkt) begin
          if (!sync_q[ch]) begin
            sync_d[ch] = 1'b1;
          end else if (seq_cur != exp_seq_q[ch]) begin
            lost_d[ch]   = lost_sum[CNT_WIDTH] ? '1 : lost_sum[CNT_WIDTH-1:0];
            sticky_d[ch] = 1'b1;
          end
          exp_seq_d[ch] = seq_cur + 16'd1;
        end
      end
    end

    // Clear wins over any same-cycle update; packet tracking itself is untouched.
    if (clear_stats_i) begin
      good_d   = '{default: '0};
      bad_d    = '{default: '0};
      lost_d   = '{default: '0};
      sticky_d = '0;
      sync_d   = '0;
    end
  end

  // Backpressure pattern; tready is registered so it never follows tvalid.
  always_comb begin
    lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    bp_cnt_d = bp_cnt_q + 2'd1;
    case (bp_mode_i)
      2'd1:    tready_d = lfsr_d[0];
      2'd2:    tready_d = (bp_cnt_d == 2'd0);
      default: tready_d = 1'b1;
    endcase
  end

  // Channel state, statistics and completion pulse registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= '{default: StIdle};
      byte_cnt_q <= '{default: '0};
      hdr_seq_q  <= '{default: '0};
      hdr_len_q  <= '{default: '0};
      exp_seq_q  <= '{default: '0};
      good_q     <= '{default: '0};
      bad_q      <= '{default: '0};
      lost_q     <= '{default: '0};
      err_q      <= '0;
      sync_q     <= '0;
      sticky_q   <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      chan_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_seq_q  <= hdr_seq_d;
      hdr_len_q  <= hdr_len_d;
      exp_seq_q  <= exp_seq_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      lost_q     <= lost_d;
      err_q      <= err_d;
      sync_q     <= sync_d;
      sticky_q   <= sticky_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      chan_q     <= chan_d;
    end
  end

  // Backpressure generator state and selected-channel statistics view.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      lfsr_q      <= LFSR_SEED;
      bp_cnt_q    <= '0;
      tready_q    <= 1'b0;
      stat_good_q <= '0;
      stat_bad_q  <= '0;
      stat_lost_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      bp_cnt_q <= bp_cnt_d;
      tready_q <= tready_d;
      if (32'(stat_sel_i) < NUM_CHANNELS) begin
        stat_good_q <= good_q[stat_sel_i];
        stat_bad_q  <= bad_q[stat_sel_i];
        stat_lost_q <= lost_q[stat_sel_i];
      end else begin
        stat_good_q <= '0;
        stat_bad_q  <= '0;
        stat_lost_q <= '0;
      end
    end
  end

  assign axis_in.tready = tready_q;
  assign stat_good_o    = stat_good_q;
  assign stat_bad_o     = stat_bad_q;
  assign stat_lost_o    = stat_lost_q;
  assign err_sticky_o   = sticky_q;
  assign pkt_done_o     = done_q;
  assign pkt_ok_o       = ok_q;
  assign pkt_chan_o     = chan_q;
endmodule

// File: tb/tb_axis_multi_channel_packet_checker.sv
// Directed bench for the multi-channel packet checker: a packet table plus corner sequences.
module tb_axis_multi_channel_packet_checker;
  logic        clk = 1'b0;
  logic        areset;
  logic [1:0]  bp_mode;
  logic        clear_stats;
  logic [1:0]  stat_sel;
  logic [31:0] stat_good, stat_bad, stat_lost;
  logic [3:0]  err_sticky;
  logic        pkt_done, pkt_ok;
  logic [1:0]  pkt_chan;

  int errors  = 0;
  int checks  = 0;
  int ok_seen = 0;

  always #5 clk = ~clk;

  axis_multi_channel_packet_checker_if #(.DATA_BYTES(8), .DEST_W(4)) axis_if ();

  axis_multi_channel_packet_checker dut (
    .clk          (clk),
    .areset       (areset),
    .axis_in      (axis_if.slave),
    .bp_mode_i    (bp_mode),
    .clear_stats_i(clear_stats),
    .stat_sel_i   (stat_sel),
    .stat_good_o  (stat_good),
    .stat_bad_o   (stat_bad),
    .stat_lost_o  (stat_lost),
    .err_sticky_o (err_sticky),
    .pkt_done_o   (pkt_done),
    .pkt_ok_o     (pkt_ok),
    .pkt_chan_o   (pkt_chan)
  );

  always @(negedge clk) if (pkt_done === 1'b1 && pkt_ok === 1'b1) ok_seen++;

  typedef struct {
    logic [3:0]  dest;
    logic [15:0] seq;
    logic [15:0] hlen;
    int          nbytes;
    int          corrupt;
    logic        exp_ok;
    logic [1:0]  exp_chan;
    logic [3:0]  exp_sticky;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [15:0] seq, input logic [15:0] hlen,
                                            input int b, input int corrupt);
    logic [63:0] d;
    logic [7:0]  v;
    int          i;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      i = b * 8 + j;
      if (i == 0)      v = seq[7:0];
      else if (i == 1) v = seq[15:8];
      else if (i == 2) v = hlen[7:0];
      else if (i == 3) v = hlen[15:8];
      else             v = seq[7:0] + 8'(i);
      if (i == corrupt) v = v ^ 8'hFF;
      d[8*j +: 8] = v;
    end
    return d;
  endfunction

  // Called at a negedge; returns at the negedge right after the beat was accepted.
  task automatic beat(input logic [3:0] dest, input logic [63:0] d, input logic [7:0] k,
                      input logic l);
    int n = 0;
    axis_if.tdata  = d;
    axis_if.tkeep  = k;
    axis_if.tlast  = l;
    axis_if.tdest  = dest;
    axis_if.tvalid = 1'b1;
    while (axis_if.tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: tready low for %0d cycles, required 1", n);
    end
    @(negedge clk);
    axis_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] dest, input logic [15:0] seq, input logic [15:0] hlen,
                          input int nbytes, input int corrupt);
    int         nb;
    int         rem;
    logic [7:0] k;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      rem = nbytes - b * 8;
      k   = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      beat(dest, beat_data(seq, hlen, b, corrupt), k, b == nb - 1);
    end
  endtask

  task automatic chk_stats(input logic [1:0] ch, input int g, input int b, input int l,
                           input string tag);
    stat_sel = ch;
    repeat (2) @(negedge clk);
    chk({tag, "_good"}, stat_good, g);
    chk({tag, "_bad"},  stat_bad,  b);
    chk({tag, "_lost"}, stat_lost, l);
  endtask

  initial begin
    int hi;
    int ok_base;

    vecs[0]  = '{4'd0, 16'd5,      16'd64,   64,   -1, 1'b1, 2'd0, 4'b0000};
    vecs[1]  = '{4'd0, 16'd6,      16'd64,   64,   -1, 1'b1, 2'd0, 4'b0000};
    vecs[2]  = '{4'd0, 16'd7,      16'd64,   64,   -1, 1'b1, 2'd0, 4'b0000};
    vecs[3]  = '{4'd1, 16'd10,     16'd16,   16,   -1, 1'b1, 2'd1, 4'b0000};
    vecs[4]  = '{4'd1, 16'd13,     16'd16,   16,   -1, 1'b1, 2'd1, 4'b0010};
    vecs[5]  = '{4'd2, 16'hFFFF,   16'd24,   24,   -1, 1'b1, 2'd2, 4'b0010};
    vecs[6]  = '{4'd2, 16'h0000,   16'd24,   24,   -1, 1'b1, 2'd2, 4'b0010};
    vecs[7]  = '{4'd3, 16'd1,      16'd20,   20,    9, 1'b0, 2'd3, 4'b1010};
    vecs[8]  = '{4'd3, 16'd2,      16'd40,   36,   -1, 1'b0, 2'd3, 4'b1010};
    vecs[9]  = '{4'd5, 16'd0,      16'd8,    8,    -1, 1'b0, 2'd0, 4'b1011};
    vecs[10] = '{4'd2, 16'd0,      16'd3,    3,    -1, 1'b0, 2'd2, 4'b1111};
    vecs[11] = '{4'd2, 16'd1,      16'd8,    8,    -1, 1'b1, 2'd2, 4'b1111};
    vecs[12] = '{4'd1, 16'd14,     16'd9608, 9608, -1, 1'b0, 2'd1, 4'b1111};
    vecs[13] = '{4'd1, 16'd15,     16'd9600, 9600, -1, 1'b1, 2'd1, 4'b1111};

    areset         = 1'b1;
    axis_if.tvalid = 1'b0;
    axis_if.tdata  = '0;
    axis_if.tkeep  = '0;
    axis_if.tlast  = 1'b0;
    axis_if.tdest  = '0;
    bp_mode        = 2'd0;
    clear_stats    = 1'b0;
    stat_sel       = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_tready", axis_if.tready, 0);
    chk("rst_done",   pkt_done,   0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_good",   stat_good,  0);
    areset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", axis_if.tready, 1);

    for (int r = 0; r < 14; r++) begin
      send_pkt(vecs[r].dest, vecs[r].seq, vecs[r].hlen, vecs[r].nbytes, vecs[r].corrupt);
      chk($sformatf("row%0d_done", r),   pkt_done,   1);
      chk($sformatf("row%0d_ok", r),     pkt_ok,     vecs[r].exp_ok);
      chk($sformatf("row%0d_chan", r),   pkt_chan,   vecs[r].exp_chan);
      chk($sformatf("row%0d_sticky", r), err_sticky, vecs[r].exp_sticky);
      @(negedge clk);
      chk($sformatf("row%0d_pulse", r),  pkt_done,   0);
    end
    chk_stats(2'd0, 3, 1, 0, "tbl_ch0");
    chk_stats(2'd1, 3, 1, 2, "tbl_ch1");
    chk_stats(2'd2, 3, 1, 0, "tbl_ch2");
    chk_stats(2'd3, 0, 2, 0, "tbl_ch3");

    // One-in-four backpressure.
    bp_mode = 2'd2;
    repeat (3) @(negedge clk);
    hi = 0;
    repeat (16) begin
      @(negedge clk);
      if (axis_if.tready === 1'b1) hi++;
    end
    chk("bp2_duty", hi, 4);

    // Interleaved ch0/ch1 traffic under LFSR backpressure.
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("clr_sticky", err_sticky, 0);
    bp_mode = 2'd1;
    ok_base = ok_seen;
    for (int p = 0; p < 100; p++) begin
      beat(4'd0, beat_data(16'(100 + p), 16'd16, 0, -1), 8'hFF, 1'b0);
      beat(4'd1, beat_data(16'(300 + p), 16'd16, 0, -1), 8'hFF, 1'b0);
      beat(4'd0, beat_data(16'(100 + p), 16'd16, 1, -1), 8'hFF, 1'b1);
      beat(4'd1, beat_data(16'(300 + p), 16'd16, 1, -1), 8'hFF, 1'b1);
    end
    repeat (3) @(negedge clk);
    chk("ilv_ok_pulses", ok_seen - ok_base, 200);
    chk_stats(2'd0, 100, 0, 0, "ilv_ch0");
    chk_stats(2'd1, 100, 0, 0, "ilv_ch1");
    chk("ilv_sticky", err_sticky, 0);

    // Clear in the pkt_done cycle of a gapped ch0 packet.
    bp_mode = 2'd0;
    repeat (2) @(negedge clk);
    send_pkt(4'd0, 16'd500, 16'd16, 16, -1);
    chk("clr_done", pkt_done, 1);
    chk("clr_sticky_set", err_sticky, 4'b0001);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk_stats(2'd0, 0, 0, 0, "clr_ch0");
    chk("clr_sticky_zero", err_sticky, 0);
    send_pkt(4'd0, 16'd900, 16'd16, 16, -1);
    chk("resync_ok", pkt_ok, 1);
    chk_stats(2'd0, 1, 0, 0, "resync_ch0");

    // Reset in the middle of a ch3 packet.
    beat(4'd3, beat_data(16'd7, 16'd24, 0, -1), 8'hFF, 1'b0);
    areset = 1'b1;
    #1;
    chk("mid_rst_tready", axis_if.tready, 0);
    chk("mid_rst_sticky", err_sticky, 0);
    chk("mid_rst_good",   stat_good,  0);
    chk("mid_rst_done",   pkt_done,   0);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    beat(4'd3, beat_data(16'd7, 16'd24, 1, -1), 8'hFF, 1'b0);
    beat(4'd3, beat_data(16'd7, 16'd24, 2, -1), 8'hFF, 1'b1);
    chk("tail_done", pkt_done, 1);
    chk("tail_ok",   pkt_ok,   0);
    chk("tail_chan", pkt_chan, 3);
    send_pkt(4'd3, 16'd50, 16'd24, 24, -1);
    chk("clean_ok", pkt_ok, 1);
    chk_stats(2'd3, 1, 1, 61474, "rst_ch3");
    chk("rst_sticky_ch3", err_sticky, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
